// File: rtl/hazard_stall_controller.sv
// RAW interlock for the 5-stage pipeline without forwarding.
// Two-slot (EX, MEM) write scoreboard, memory freeze and stall counter.
module hazard_stall_controller #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      id_inst,
    input  logic             id_valid,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             pipe_en,
    output logic             idex_bubble,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [2:0] OP_LDM = 3'b001;
    localparam logic [2:0] OP_STD = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    logic [2:0]            opcode;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic                  reads_a;
    logic                  reads_b;
    logic                  writes;

    logic                  ex_v;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_v;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic                  hit_a;
    logic                  hit_b;
    logic                  hazard;
    logic                  freeze;

    logic                  unused_bits;

    assign opcode = id_inst[15:13];
    assign ra     = id_inst[12:10];
    assign rb     = id_inst[9:7];

    assign unused_bits = ^id_inst[6:0];

    always_comb begin
        reads_a = 1'b0;
        reads_b = 1'b0;
        writes  = 1'b0;
        unique case (opcode)
            OP_LDM: begin
                writes = 1'b1;
            end
            OP_STD: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
            end
            OP_ADD: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
                writes  = 1'b1;
            end
            OP_NOT: begin
                reads_a = 1'b1;
                writes  = 1'b1;
            end
            default: begin
                reads_a = 1'b0;
                reads_b = 1'b0;
                writes  = 1'b0;
            end
        endcase
    end

    // WB writes before ID reads in the same cycle, so only EX/MEM can conflict.
    assign hit_a = reads_a &&
                   ((ex_v && ex_rd == ra) || (mem_v && mem_rd == ra));
    assign hit_b = reads_b &&
                   ((ex_v && ex_rd == rb) || (mem_v && mem_rd == rb));

    assign hazard = id_valid && (hit_a || hit_b);
    assign freeze = mem_busy;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pipe_en     = 1'b1;
        idex_bubble = ~id_valid;
        stall       = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            pipe_en     = 1'b0;
            idex_bubble = 1'b1;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            pipe_en     = 1'b0;
            idex_bubble = 1'b0;
        end else if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v   <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_rd <= '0;
        end else if (pipe_en) begin
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= writes && id_valid && !hazard;
            ex_rd  <= ra;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if ((stall || freeze) && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with an expected-value queue.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] id_inst = 16'h0000;
    logic        id_valid = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_en, ifid_en, pipe_en, idex_bubble, stall;
    logic [15:0] stall_count;

    logic        rst2_n = 1'b0;
    logic        busy2 = 1'b0;
    logic        pc2, ifid2, pipe2, bub2, stall2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pc;
        logic        ifid;
        logic        pipe;
        logic        bub;
        logic        stl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [1:0]  q2[$];

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_ADDR_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst),
        .id_valid(id_valid), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .pipe_en(pipe_en),
        .idex_bubble(idex_bubble), .stall(stall),
        .stall_count(stall_count)
    );

    hazard_stall_controller #(.REG_ADDR_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .id_inst(16'hA000),
        .id_valid(1'b1), .mem_busy(busy2),
        .pc_en(pc2), .ifid_en(ifid2), .pipe_en(pipe2),
        .idex_bubble(bub2), .stall(stall2),
        .stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic pc, input logic ifid, input logic pipe,
                        input logic bub, input logic stl,
                        input logic [15:0] cnt);
        exp_t e;
        e.pc = pc; e.ifid = ifid; e.pipe = pipe;
        e.bub = bub; e.stl = stl; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
            return;
        end
        e = q.pop_front();
        chk({tag, ".pc_en"},       {15'd0, pc_en},       {15'd0, e.pc});
        chk({tag, ".ifid_en"},     {15'd0, ifid_en},     {15'd0, e.ifid});
        chk({tag, ".pipe_en"},     {15'd0, pipe_en},     {15'd0, e.pipe});
        chk({tag, ".idex_bubble"}, {15'd0, idex_bubble}, {15'd0, e.bub});
        chk({tag, ".stall"},       {15'd0, stall},       {15'd0, e.stl});
        chk({tag, ".stall_count"}, stall_count,          e.cnt);
    endtask

    // Drive one ID-stage cycle, compare outputs mid-cycle, advance past edge.
    task automatic step(input string tag, input logic [15:0] inst,
                        input logic v, input logic busy,
                        input logic pc, input logic ifid, input logic pipe,
                        input logic bub, input logic stl,
                        input logic [15:0] cnt);
        id_inst  = inst;
        id_valid = v;
        mem_busy = busy;
        push(pc, ifid, pipe, bub, stl, cnt);
        @(negedge clk);
        pop_cmp(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        #1;
        pop_cmp(tag);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [15:0] LDM_R1 = 16'h2400;
    localparam logic [15:0] LDM_R2 = 16'h2802;
    localparam logic [15:0] ADD11  = 16'h6500;
    localparam logic [15:0] NOT_R1 = 16'h8400;
    localparam logic [15:0] STD12  = 16'h4500;
    localparam logic [15:0] NOP    = 16'hA000;

    initial begin
        #2;
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        pop_cmp("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // producer one ahead: two stall cycles
        step("s1_ldm",  LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s1_st1",  ADD11,  1, 0, 0, 0, 1, 1, 1, 16'd0);
        step("s1_st2",  ADD11,  1, 0, 0, 0, 1, 1, 1, 16'd1);
        step("s1_iss",  ADD11,  1, 0, 1, 1, 1, 0, 0, 16'd2);
        step("s1_empty", 16'h0, 0, 0, 1, 1, 1, 1, 0, 16'd2);

        // producer two ahead: one stall; three ahead: none
        do_reset("s2_rst");
        step("s2_ldm",  LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s2_nop",  NOP,    1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s2_st1",  ADD11,  1, 0, 0, 0, 1, 1, 1, 16'd0);
        step("s2_iss",  ADD11,  1, 0, 1, 1, 1, 0, 0, 16'd1);
        step("s2b_ldm", LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd1);
        step("s2b_nop1", NOP,   1, 0, 1, 1, 1, 0, 0, 16'd1);
        step("s2b_nop2", NOP,   1, 0, 1, 1, 1, 0, 0, 16'd1);
        step("s2b_add", ADD11,  1, 0, 1, 1, 1, 0, 0, 16'd1);

        // unrelated register, then store consumer
        do_reset("s3_rst");
        step("s3_ldm2", LDM_R2, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s3_not",  NOT_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s3_ldm1", LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s3_st1",  STD12,  1, 0, 0, 0, 1, 1, 1, 16'd0);
        step("s3_st2",  STD12,  1, 0, 0, 0, 1, 1, 1, 16'd1);
        step("s3_iss",  STD12,  1, 0, 1, 1, 1, 0, 0, 16'd2);

        // freeze over a pending hazard keeps its depth
        do_reset("s4_rst");
        step("s4_ldm",  LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        step("s4_fz1",  ADD11,  1, 1, 0, 0, 0, 0, 0, 16'd0);
        step("s4_fz2",  ADD11,  1, 1, 0, 0, 0, 0, 0, 16'd1);
        step("s4_fz3",  ADD11,  1, 1, 0, 0, 0, 0, 0, 16'd2);
        step("s4_st1",  ADD11,  1, 0, 0, 0, 1, 1, 1, 16'd3);
        step("s4_st2",  ADD11,  1, 0, 0, 0, 1, 1, 1, 16'd4);
        step("s4_iss",  ADD11,  1, 0, 1, 1, 1, 0, 0, 16'd5);

        // asynchronous reset in the middle of a stall
        do_reset("s5_rst");
        step("s5_ldm",  LDM_R1, 1, 0, 1, 1, 1, 0, 0, 16'd0);
        id_inst  = ADD11;
        push(0, 0, 1, 1, 1, 16'd0);
        @(negedge clk);
        pop_cmp("s5_st1");
        @(posedge clk);
        #1;
        push(0, 0, 1, 1, 1, 16'd1);
        #2;
        pop_cmp("s5_st2");
        rst_n = 1'b0;
        push(0, 0, 0, 1, 0, 16'd0);
        #1;
        pop_cmp("s5_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("s5_iss",  ADD11,  1, 0, 1, 1, 1, 0, 0, 16'd0);

        // CNT_W=2 saturation under continuous freeze
        busy2 = 1'b1;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        q2.push_back(2'd1);
        q2.push_back(2'd2);
        q2.push_back(2'd3);
        q2.push_back(2'd3);
        q2.push_back(2'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s6_cnt%0d", i), {14'd0, cnt2},
                {14'd0, q2.pop_front()});
        end
        chk("s6_pipe_en", {15'd0, pipe2}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Load-use / RAW interlock controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). There is no forwarding network, so this block keeps a two-slot scoreboard of in-flight register writes in EX and MEM. It stalls IF/ID and inserts a bubble into ID/EX whenever the instruction in ID reads a register that is still pending. It also freezes the whole pipeline while data memory is busy, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_ADDR_W, 3, register address width (8 registers, R0 is a normal register)
- CNT_W, 16, width of stall_count
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_inst  in  16  instruction currently held in IF/ID
- id_valid  in  1  IF/ID holds a real instruction (0 = empty slot)
- mem_busy  in  1  data memory not ready; freezes the entire pipeline
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID register load enable
- pipe_en  out  1  load enable for ID/EX, EX/MEM and MEM/WB
- idex_bubble  out  1  force ID/EX control fields to zero (NOP)
- stall  out  1  data-hazard stall this cycle
- stall_count  out  CNT_W  cycles with stall or freeze, saturating

## Operation
- Decode fields:
  - opcode = id_inst[15:13]
  - ra = id_inst[12:10]
  - rb = id_inst[9:7]
- Per-opcode register usage:
  - 001 LDM: reads none, writes ra.
  - 010 STD: reads ra and rb, writes none.
  - 011 ADD: reads ra and rb, writes ra.
  - 100 NOT: reads ra, writes ra.
  - 101 NOP and every other opcode: reads none, writes none.
- Scoreboard: registers ex_v/ex_rd and mem_v/mem_rd. A slot is pending when v=1.
- The register file writes in the first half-cycle and reads in the second, so a producer in WB never causes a hazard. Only the EX and MEM slots are compared.
- hazard = id_valid AND a read register equals ex_rd (with ex_v) or mem_rd (with mem_v).
- freeze = mem_busy.
- Output equations:
  - freeze=1: pc_en=0, ifid_en=0, pipe_en=0, idex_bubble=0, stall=0. Freeze dominates a simultaneous hazard.
  - else hazard=1: pc_en=0, ifid_en=0, pipe_en=1, idex_bubble=1, stall=1.
  - else: pc_en=1, ifid_en=1, pipe_en=1, stall=0, idex_bubble=~id_valid.
- Scoreboard update on the clock edge when pipe_en=1:
  - mem <= ex.
  - ex <= {writes, ra} if (id_valid AND NOT hazard), else {0, x}.
- Scoreboard update when pipe_en=0: both slots hold.
- stall_count increments by 1 on every edge where stall=1 or freeze=1. It saturates at all-ones and never wraps.
- All outputs except stall_count are combinational from id_inst, id_valid, mem_busy and the scoreboard. There is no combinational path from any output back to an input.

## Timing
- Reset (rst_n=0, asynchronous):
  - ex_v=0, mem_v=0, stall_count=0.
  - While reset is held the outputs are forced to pc_en=0, ifid_en=0, pipe_en=0, idex_bubble=1, stall=0.
- First edge after rst_n rises: normal operation, scoreboard empty.
- Stall depth for a consumer directly in ID:
  - Producer one instruction ahead (in EX): 2 stall cycles.
  - Producer two instructions ahead (in MEM): 1 stall cycle.
  - Producer three or more instructions ahead: 0 stall cycles.
- A bubble inserted by a stall enters ex as empty, so the producer drains one slot per unfrozen cycle.
- Freeze holds every piece of state, including the pending hazard, for exactly the mem_busy cycles. The hazard resumes with the same remaining depth afterwards.
- Reset asserted mid-stall or mid-freeze clears the scoreboard and the counter immediately. It does not wait for a clock edge.

## Test plan
- LDM R1 (2400) then ADD (6500), both id_valid=1 back-to-back -> stall=1 for 2 cycles with idex_bubble=1 and pc_en=0; ADD issues on the 3rd cycle; stall_count=2.
- LDM R1, NOP (A000), ADD (6500) -> exactly 1 stall cycle; stall_count=1. LDM R1, NOP, NOP, ADD -> 0 stalls.
- LDM R2 (2802) then NOT R1 (8400) -> no stall. LDM R1 then STD (4500) -> 2 stalls.
- LDM R1, then ADD in ID with mem_busy=1 for 3 cycles on the first hazard cycle -> pipe_en=pc_en=0 and stall=0 for 3 cycles with scoreboard held; then 2 stall cycles; stall_count=5.
- CNT_W=2 with continuous mem_busy=1 -> stall_count goes 1, 2, 3, 3, 3 (saturates, no wrap).
- rst_n pulsed low between the 2 stall cycles of the first scenario -> counter reads 0 immediately and the outputs take their reset values; after release ADD issues with no stall.
